// File: rtl/uart_cmd_slave.sv
// UART command slave: assembles 3-byte (MSB first) host commands into a 24-bit word
// and serialises 8-bit responses back to the host. RX and TX run independently.
module uart_cmd_slave #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RX,
  output logic        TX,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic {TX_IDLE, TX_XMIT} tx_state_e;

  rx_state_e   rx_state_q, rx_state_d;
  tx_state_e   tx_state_q, tx_state_d;

  logic        rx_meta_q, rx_meta_d;
  logic        rx_sync_q, rx_sync_d;
  logic        rx_prev_q, rx_prev_d;
  logic [15:0] rx_baud_q, rx_baud_d;
  logic [3:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] hold_q, hold_d;
  logic [23:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;

  logic [15:0] tx_baud_q, tx_baud_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic [9:0]  tx_frame_q, tx_frame_d;
  logic        resp_sent_q, resp_sent_d;

  logic        rx_fall, rx_half_hit, rx_full_hit, tx_full_hit;
  logic        byte_valid, frame_err;

  assign rx_fall     = rx_prev_q & ~rx_sync_q;
  assign rx_half_hit = (rx_baud_q == HALF_LAST);
  assign rx_full_hit = (rx_baud_q == BAUD_LAST);
  assign tx_full_hit = (tx_baud_q == BAUD_LAST);

  // RX state register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      byte_cnt_q <= '0;
      hold_q     <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      byte_cnt_q <= byte_cnt_d;
      hold_q     <= hold_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
      RX_START: if (rx_half_hit) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_full_hit && (rx_bit_q == 4'd7)) rx_state_d = RX_STOP;
      RX_STOP:  if (rx_full_hit) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_meta_d  = RX;
    rx_sync_d  = rx_meta_q;
    rx_prev_d  = rx_sync_q;
    rx_baud_d  = rx_baud_q + 16'd1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: rx_baud_d = '0;
      RX_DATA: begin
        if (rx_full_hit) begin
          rx_baud_d  = '0;
          rx_bit_d   = rx_bit_q + 4'd1;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        end
      end
      RX_STOP: begin
        if (rx_full_hit) begin
          byte_valid = rx_sync_q;
          frame_err  = ~rx_sync_q;
        end
      end
      default: ;
    endcase
    if (rx_state_d != rx_state_q) begin
      rx_baud_d = '0;
      rx_bit_d  = '0;
    end
  end

  // A byte-3 completion sets cmd_rdy after any clear, so the set wins
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    hold_d     = hold_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = cmd_rdy_q;
    if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
    if (frame_err) begin
      byte_cnt_d = 2'd0;
    end else if (byte_valid) begin
      case (byte_cnt_q)
        2'd0: begin
          hold_d[15:8] = rx_shift_q;
          byte_cnt_d   = 2'd1;
          cmd_rdy_d    = 1'b0;
        end
        2'd1: begin
          hold_d[7:0] = rx_shift_q;
          byte_cnt_d  = 2'd2;
        end
        default: begin
          cmd_d      = {hold_q, rx_shift_q};
          cmd_rdy_d  = 1'b1;
          byte_cnt_d = 2'd0;
        end
      endcase
    end
  end

  // TX state register and datapath flops; TX is the LSB of the frame shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_baud_q   <= '0;
      tx_bit_q    <= '0;
      tx_frame_q  <= '1;
      resp_sent_q <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_baud_q   <= tx_baud_d;
      tx_bit_q    <= tx_bit_d;
      tx_frame_q  <= tx_frame_d;
      resp_sent_q <= resp_sent_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    case (tx_state_q)
      TX_IDLE: if (send_resp) tx_state_d = TX_XMIT;
      TX_XMIT: if (tx_full_hit && (tx_bit_q == 4'd9)) tx_state_d = TX_IDLE;
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_baud_d   = tx_baud_q + 16'd1;
    tx_bit_d    = tx_bit_q;
    tx_frame_d  = tx_frame_q;
    resp_sent_d = resp_sent_q;
    case (tx_state_q)
      TX_IDLE: begin
        tx_baud_d = '0;
        if (send_resp) begin
          tx_frame_d  = {1'b1, resp, 1'b0};
          resp_sent_d = 1'b0;
        end
      end
      TX_XMIT: begin
        if (tx_full_hit) begin
          tx_baud_d  = '0;
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_frame_d = {1'b1, tx_frame_q[9:1]};
          if (tx_bit_q == 4'd9) resp_sent_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (tx_state_d != tx_state_q) begin
      tx_baud_d = '0;
      tx_bit_d  = '0;
    end
  end

  assign TX        = tx_frame_q[0];
  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;

endmodule

// File: tb/tb_uart_cmd_slave.sv
// Directed bench for uart_cmd_slave at BAUD_DIV=16: command receive, framing error,
// glitch rejection, response transmit and mid-frame reset.
module tb_uart_cmd_slave;

  localparam int BAUD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        RX;
  logic        TX;
  logic [23:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  int test_count = 0;
  int fail_count = 0;

  uart_cmd_slave #(.BAUD_DIV(BAUD)) dut (
    .clk         (clk),
    .rst         (rst),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one UART frame on RX, starting and ending on a falling clock edge
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input int stop_cycles);
    RX = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = data[i];
      repeat (BAUD) @(negedge clk);
    end
    RX = stop_bit;
    repeat (stop_cycles) @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic sendCommand(input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    applyStimulus(b1, 1'b1, BAUD);
    applyStimulus(b2, 1'b1, BAUD);
    applyStimulus(b3, 1'b1, BAUD);
  endtask

  logic [9:0] frame_a5;

  initial begin
    rst         = 1'b1;
    RX          = 1'b1;
    clr_cmd_rdy = 1'b0;
    resp        = 8'h00;
    send_resp   = 1'b0;
    frame_a5    = {1'b1, 8'hA5, 1'b0};
    repeat (4) @(negedge clk);

    // Reset state
    checkOutput("reset_tx", 32'(TX), 32'd1);
    checkOutput("reset_cmd", 32'(cmd), 32'h0);
    checkOutput("reset_cmd_rdy", 32'(cmd_rdy), 32'd0);
    checkOutput("reset_resp_sent", 32'(resp_sent), 32'd0);
    rst = 1'b0;
    idleCycles(8);

    // First command 02_0000; cmd must still be 0 partway through the last stop bit
    applyStimulus(8'h02, 1'b1, BAUD);
    applyStimulus(8'h00, 1'b1, BAUD);
    applyStimulus(8'h00, 1'b1, 4);
    checkOutput("cmd1_before_cmd", 32'(cmd), 32'h0);
    checkOutput("cmd1_before_rdy", 32'(cmd_rdy), 32'd0);
    idleCycles(BAUD - 4);
    checkOutput("cmd1_cmd", 32'(cmd), 32'h020000);
    checkOutput("cmd1_rdy", 32'(cmd_rdy), 32'd1);

    // Back-to-back commands without acknowledgement
    sendCommand(8'h03, 8'h00, 8'h2E);
    checkOutput("cmd2_cmd", 32'(cmd), 32'h03002E);
    checkOutput("cmd2_rdy", 32'(cmd_rdy), 32'd1);
    applyStimulus(8'h04, 1'b1, BAUD);
    checkOutput("cmd3_b1_rdy", 32'(cmd_rdy), 32'd0);
    checkOutput("cmd3_b1_cmd", 32'(cmd), 32'h03002E);
    applyStimulus(8'h01, 1'b1, BAUD);
    checkOutput("cmd3_b2_cmd", 32'(cmd), 32'h03002E);
    applyStimulus(8'h00, 1'b1, BAUD);
    checkOutput("cmd3_cmd", 32'(cmd), 32'h040100);
    checkOutput("cmd3_rdy", 32'(cmd_rdy), 32'd1);

    // Dispatcher acknowledgement
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    checkOutput("clr_rdy", 32'(cmd_rdy), 32'd0);
    checkOutput("clr_cmd_hold", 32'(cmd), 32'h040100);

    // Framing error on byte 2 resets the byte counter
    applyStimulus(8'h11, 1'b1, BAUD);
    applyStimulus(8'h22, 1'b0, BAUD);
    idleCycles(BAUD);
    checkOutput("ferr_rdy", 32'(cmd_rdy), 32'd0);
    applyStimulus(8'hA5, 1'b1, BAUD);
    applyStimulus(8'h5A, 1'b1, BAUD);
    checkOutput("ferr_two_bytes_rdy", 32'(cmd_rdy), 32'd0);
    checkOutput("ferr_two_bytes_cmd", 32'(cmd), 32'h040100);
    applyStimulus(8'h3C, 1'b1, BAUD);
    checkOutput("ferr_cmd", 32'(cmd), 32'hA55A3C);
    checkOutput("ferr_rdy_set", 32'(cmd_rdy), 32'd1);

    // 4-cycle glitch must be rejected as a false start
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    RX = 1'b0;
    repeat (4) @(negedge clk);
    idleCycles(30);
    checkOutput("glitch_rdy", 32'(cmd_rdy), 32'd0);
    checkOutput("glitch_cmd", 32'(cmd), 32'hA55A3C);
    sendCommand(8'h5A, 8'h12, 8'h34);
    checkOutput("glitch_next_cmd", 32'(cmd), 32'h5A1234);
    checkOutput("glitch_next_rdy", 32'(cmd_rdy), 32'd1);

    // Response A5 with an ignored second strobe at cycle 50
    resp      = 8'hA5;
    send_resp = 1'b1;
    for (int c = 0; c <= 10 * BAUD; c++) begin
      @(negedge clk);
      if (c == 0) begin
        send_resp = 1'b0;
        checkOutput("tx_start_edge", 32'(TX), 32'd0);
        checkOutput("tx_resp_sent_clr", 32'(resp_sent), 32'd0);
      end
      if (c % BAUD == 7) checkOutput($sformatf("tx_bit%0d", c / BAUD), 32'(TX), 32'(frame_a5[c / BAUD]));
      if (c == 50) begin
        resp      = 8'hFF;
        send_resp = 1'b1;
      end
      if (c == 51) send_resp = 1'b0;
      if (c == 10 * BAUD - 1) checkOutput("tx_resp_sent_early", 32'(resp_sent), 32'd0);
      if (c == 10 * BAUD) begin
        checkOutput("tx_resp_sent", 32'(resp_sent), 32'd1);
        checkOutput("tx_idle", 32'(TX), 32'd1);
      end
    end
    idleCycles(BAUD);
    checkOutput("tx_resp_sent_hold", 32'(resp_sent), 32'd1);

    // Reset mid TX frame and mid byte 2 of a command
    applyStimulus(8'h77, 1'b1, BAUD);
    resp      = 8'h00;
    send_resp = 1'b1;
    fork
      applyStimulus(8'hFF, 1'b1, BAUD);
      begin
        @(negedge clk);
        send_resp = 1'b0;
        repeat (68) @(negedge clk);
        checkOutput("rst_tx_before", 32'(TX), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_tx", 32'(TX), 32'd1);
        checkOutput("rst_cmd", 32'(cmd), 32'h0);
        checkOutput("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        checkOutput("rst_resp_sent", 32'(resp_sent), 32'd0);
        rst = 1'b0;
      end
    join
    idleCycles(2 * BAUD);
    checkOutput("rst_tx_idle", 32'(TX), 32'd1);
    sendCommand(8'hC3, 8'h81, 8'h7E);
    checkOutput("rst_next_cmd", 32'(cmd), 32'hC3817E);
    checkOutput("rst_next_rdy", 32'(cmd_rdy), 32'd1);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/uart_cmd_slave.md
# uart_cmd_slave

Device-side end of the host UART command link. It receives the 24-bit commands that the host UART master sends as three serial bytes, most-significant byte first, and presents each one to the command dispatcher as a parallel word with a ready flag. It also serialises the dispatcher's 8-bit responses, such as acks and read data, back to the host. It sits between the `RX`/`TX` pins of DSO_dig and the command-processing FSM.

## Interface
- `BAUD_DIV`, default 2604: clock cycles per UART bit. Legal range is 16 to 65535.
- `clk  in  1`: system clock; every flop is on the rising edge.
- `rst  in  1`: reset, synchronous and active-high.
- `RX  in  1`: serial input from the host. Asynchronous; idles high.
- `TX  out  1`: serial output to the host; idles high.
- `cmd  out  24`: last complete command. Bits [23:16] are byte 1, [15:8] byte 2, [7:0] byte 3.
- `cmd_rdy  out  1`: a new command is held in `cmd`.
- `clr_cmd_rdy  in  1`: dispatcher acknowledgement; clears `cmd_rdy`.
- `resp  in  8`: response byte to transmit.
- `send_resp  in  1`: single-cycle strobe that starts transmission of `resp`.
- `resp_sent  out  1`: the last response has been fully transmitted.

## Operation
- Reset values:
  - `TX`=1, `cmd`=0, `cmd_rdy`=0, `resp_sent`=0.
  - Byte counter = 0; both FSMs in IDLE.
  - RX synchroniser flops preset to 1.
- RX synchronisation: two flops. All RX logic uses the synchronised value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a synchronised falling edge.
  - START samples at BAUD_DIV/2 (integer divide) cycles. If the line is low, go to DATA. If it is high, this is a false start: return to IDLE with no effect.
  - DATA samples every BAUD_DIV cycles, 8 bits, LSB first.
  - STOP samples once more after BAUD_DIV cycles. Stop bit = 1 means the byte is valid. Stop bit = 0 is a framing error: discard the byte, force the byte counter to 0, and return to IDLE.
- Command assembly:
  - Bytes 1 and 2 go into an internal 16-bit holding register.
  - On a valid byte 3, load `cmd` = {byte1, byte2, byte3}, set `cmd_rdy`, and reset the counter to 0.
  - `cmd` changes only on byte-3 completion, so it stays stable while the next command arrives.
- `cmd_rdy` clear:
  - `clr_cmd_rdy` clears it.
  - A valid byte 1 of the next command also clears it.
  - If a clear and a byte-3 completion fall in the same cycle, the set wins.
- TX FSM states: IDLE, XMIT.
  - In IDLE, `send_resp` latches `resp` into a 10-bit frame {1, resp, 0} and moves to XMIT.
  - XMIT shifts the frame LSB first with BAUD_DIV cycles per bit.
  - After the tenth bit period the FSM returns to IDLE and `TX`=1.
  - `send_resp` during XMIT is ignored; the frame in progress is unaffected.
- `resp_sent`: cleared by an accepted `send_resp`, set at the end of the stop bit, and held until the next accepted `send_resp`.
- RX and TX are independent and run full-duplex.

## Timing
- RX latency:
  - The stop-bit sample falls 9.5·BAUD_DIV cycles (±1) after the synchronised start edge, plus 2 cycles of synchroniser delay.
  - `cmd`/`cmd_rdy` update on the clock edge following the byte-3 stop-bit sample.
- TX:
  - `TX` goes low on the first clock edge after the cycle in which `send_resp` is high.
  - Each bit holds for exactly BAUD_DIV cycles, so a frame is 10·BAUD_DIV cycles.
  - `resp_sent` rises on the same edge that ends the stop bit. A new `send_resp` is accepted on that cycle or any later one.
- Bit counters are 4 bits and baud counters 16 bits. Both reload to 0 on every state transition; neither wraps mid-bit.
- Reset asserted mid-frame: on the next edge all outputs return to their reset values, a partial command is lost, and `TX` goes high immediately, truncating the frame.
- No inter-byte timeout. A partial command waits indefinitely and resynchronises only through a framing error or reset.

## Test plan
- BAUD_DIV=16; host sends 0x02_0000 (CFG_GAIN, gain 0, channel 0) → `cmd`=24'h020000 and `cmd_rdy`=1 one cycle after the third stop-bit sample. `cmd` keeps its reset value 0 until then.
- Send 0x03_002E then 0x04_0100 back-to-back with no `clr_cmd_rdy` → `cmd_rdy` falls when byte 0x04 completes. `cmd` stays 24'h03002E until byte 3 of the second command, then becomes 24'h040100.
- Byte 2 sent with stop bit 0 → no `cmd_rdy`. The next three valid bytes A5 5A 3C → `cmd`=24'hA55A3C.
- 4-cycle low glitch on `RX` → no state change. The following byte is received correctly.
- `send_resp` with `resp`=8'hA5 → `TX` low for 16 cycles, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high. `resp_sent` rises at cycle 160. A second `send_resp` at cycle 50 is ignored.
- Assert `rst` at cycle 70 of a TX frame and midway through byte 2 of a command → `TX`=1 next edge. A fresh three-byte command afterwards decodes correctly.
